// File: rtl/brg_cgra_pkg.sv
// brg_cgra_pkg: shared constants and types for the CGRA link concentrator.
//   brg_cgra_num_links_gp : number of SDR link ports feeding the accelerator
//   brg_cgra_link_id_t    : index of one link port
package brg_cgra_pkg;

  localparam int brg_cgra_num_links_gp = 4;

  typedef logic [1:0] brg_cgra_link_id_t;

endpackage

// File: rtl/bsg_arb_round_robin.sv
// bsg_arb_round_robin: round-robin arbiter with an internal priority pointer.
// Ports:
//   clk, reset : clock, async active-high reset (pointer returns to 0)
//   en         : grants may be issued this cycle
//   reqs       : request vector
//   grants     : one-hot grant (zero when en is low or no request)
//   v          : a grant is issued this cycle
//   tag        : index of the granted requester
module bsg_arb_round_robin #(
  parameter int width_p = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               en,
  input  logic [width_p-1:0]                 reqs,
  output logic [width_p-1:0]                 grants,
  output logic                               v,
  output logic [((width_p > 1) ? $clog2(width_p) : 1)-1:0] tag
);

  localparam int id_w = (width_p > 1) ? $clog2(width_p) : 1;

  logic [id_w-1:0] ptr;

  // Scan requesters starting at the pointer; the first valid one wins.
  always_comb begin
    int idx;
    grants = '0;
    v      = 1'b0;
    tag    = '0;
    idx    = 0;
    for (int k = 0; k < width_p; k++) begin
      idx = int'(ptr) + k;
      if (idx >= width_p) idx = idx - width_p;
      if (en && !v && reqs[idx]) begin
        grants[idx] = 1'b1;
        v           = 1'b1;
        tag         = id_w'(idx);
      end
    end
  end

  // The winner drops to lowest priority; the pointer holds without a grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (v) begin
      ptr <= (tag == id_w'(width_p - 1)) ? '0 : tag + id_w'(1);
    end
  end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small: small register-based FIFO, one write and one read port.
// Ports:
//   clk, reset : clock, async active-high reset (FIFO empties)
//   push       : write wdata this cycle (caller guarantees ready)
//   wdata      : write data
//   ready      : FIFO not full
//   v          : FIFO not empty; rdata is the head entry
//   rdata      : head entry
//   yumi       : pop the head this cycle (caller guarantees v)
//   count      : number of stored entries
// els_p must be a power of two so the pointers wrap naturally.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 2,
  parameter int els_p   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [width_p-1:0]       wdata,
  output logic                     ready,
  output logic                     v,
  output logic [width_p-1:0]       rdata,
  input  logic                     yumi,
  output logic [$clog2(els_p):0]   count
);

  localparam int ptr_w = $clog2(els_p);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   wr_ptr;
  logic [ptr_w-1:0]   rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_w'(1);
      if (yumi) rd_ptr <= rd_ptr + ptr_w'(1);
      if (push && !yumi)      count <= count + (ptr_w+1)'(1);
      else if (yumi && !push) count <= count - (ptr_w+1)'(1);
    end
  end

  assign ready = (count != (ptr_w+1)'(els_p));
  assign v     = (count != '0);
  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/brg_cgra_link_concentrator.sv
// brg_cgra_link_concentrator: merges per-link request streams into the single
// accelerator request port and steers in-order returns back to their source.
// Ports:
//   clk_i, reset_i          : clock, async active-high reset
//   link_fwd_v_i/data_i     : per-link requests (link i in data slice i)
//   link_fwd_yumi_o         : per-link request dequeue, one-hot or zero
//   link_rev_v_o            : per-link return valid, one-hot or zero
//   link_rev_data_o         : return packet shared by all links
//   link_rev_ready_i        : per-link return ready
//   xcel_fwd_v_o/data_o     : registered merged request
//   xcel_fwd_ready_i        : accelerator takes the request
//   xcel_rev_v_i/data_i     : return from the accelerator
//   xcel_rev_yumi_o         : return dequeue
//   outstanding_o           : tracked outstanding requests
//   error_o                 : sticky, a return arrived with nothing tracked
module brg_cgra_link_concentrator
  import brg_cgra_pkg::*;
#(
  parameter int fwd_width_p = 8,
  parameter int rev_width_p = 8,
  parameter int num_links_p = brg_cgra_num_links_gp,
  parameter int lg_track_p  = 3
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_links_p-1:0]            link_fwd_v_i,
  input  logic [num_links_p*fwd_width_p-1:0] link_fwd_data_i,
  output logic [num_links_p-1:0]            link_fwd_yumi_o,
  output logic [num_links_p-1:0]            link_rev_v_o,
  output logic [rev_width_p-1:0]            link_rev_data_o,
  input  logic [num_links_p-1:0]            link_rev_ready_i,
  output logic                              xcel_fwd_v_o,
  output logic [fwd_width_p-1:0]            xcel_fwd_data_o,
  input  logic                              xcel_fwd_ready_i,
  input  logic                              xcel_rev_v_i,
  input  logic [rev_width_p-1:0]            xcel_rev_data_i,
  output logic                              xcel_rev_yumi_o,
  output logic [lg_track_p:0]               outstanding_o,
  output logic                              error_o
);

  localparam int id_w = (num_links_p > 1) ? $clog2(num_links_p) : 1;

  logic                   track_ready;
  logic                   track_v;
  logic [id_w-1:0]        head;
  logic                   grant_en;
  logic                   grant_v;
  logic [id_w-1:0]        grant_id;
  logic [fwd_width_p-1:0] fwd_sel;
  logic                   rev_live;

  // Fullness is judged before any same-cycle pop so grants never race a return.
  assign grant_en = (!xcel_fwd_v_o || xcel_fwd_ready_i) && track_ready;

  bsg_arb_round_robin #(.width_p(num_links_p)) arb (
    .clk    (clk_i),
    .reset  (reset_i),
    .en     (grant_en),
    .reqs   (link_fwd_v_i),
    .grants (link_fwd_yumi_o),
    .v      (grant_v),
    .tag    (grant_id)
  );

  bsg_fifo_1r1w_small #(.width_p(id_w), .els_p(2**lg_track_p)) track (
    .clk    (clk_i),
    .reset  (reset_i),
    .push   (grant_v),
    .wdata  (grant_id),
    .ready  (track_ready),
    .v      (track_v),
    .rdata  (head),
    .yumi   (xcel_rev_yumi_o),
    .count  (outstanding_o)
  );

  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < num_links_p; i++) begin
      if (link_fwd_yumi_o[i]) fwd_sel = link_fwd_data_i[i*fwd_width_p +: fwd_width_p];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      xcel_fwd_v_o    <= 1'b0;
      xcel_fwd_data_o <= '0;
    end else if (grant_v) begin
      xcel_fwd_v_o    <= 1'b1;
      xcel_fwd_data_o <= fwd_sel;
    end else if (xcel_fwd_ready_i) begin
      xcel_fwd_v_o    <= 1'b0;
    end
  end

  // Returns are strictly in order, so the FIFO head names the destination link.
  assign rev_live        = xcel_rev_v_i && track_v;
  assign link_rev_data_o = xcel_rev_data_i;
  assign xcel_rev_yumi_o = rev_live && link_rev_ready_i[head];

  always_comb begin
    link_rev_v_o = '0;
    for (int i = 0; i < num_links_p; i++) begin
      link_rev_v_o[i] = rev_live && (head == id_w'(i));
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) error_o <= 1'b0;
    else if (xcel_rev_v_i && !track_v) error_o <= 1'b1;
  end

endmodule

// File: tb/tb_brg_cgra_link_concentrator.sv
// tb_brg_cgra_link_concentrator: directed and randomized stimulus against a
// queue-based reference model of the concentrator (round-robin pick, in-order
// return steering, sticky error). Comparisons happen on the falling edge.
module tb_brg_cgra_link_concentrator;

  localparam int FW = 8;
  localparam int RW = 8;
  localparam int NL = 4;
  localparam int LT = 3;
  localparam int DEPTH = 2**LT;

  logic            clk = 1'b0;
  logic            reset;
  logic [NL-1:0]   link_fwd_v;
  logic [NL*FW-1:0] link_fwd_data;
  logic [NL-1:0]   link_fwd_yumi;
  logic [NL-1:0]   link_rev_v;
  logic [RW-1:0]   link_rev_data;
  logic [NL-1:0]   link_rev_ready;
  logic            xcel_fwd_v;
  logic [FW-1:0]   xcel_fwd_data;
  logic            xcel_fwd_ready;
  logic            xcel_rev_v;
  logic [RW-1:0]   xcel_rev_data;
  logic            xcel_rev_yumi;
  logic [LT:0]     outstanding;
  logic            error;

  brg_cgra_link_concentrator #(
    .fwd_width_p(FW), .rev_width_p(RW), .num_links_p(NL), .lg_track_p(LT)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .link_fwd_v_i     (link_fwd_v),
    .link_fwd_data_i  (link_fwd_data),
    .link_fwd_yumi_o  (link_fwd_yumi),
    .link_rev_v_o     (link_rev_v),
    .link_rev_data_o  (link_rev_data),
    .link_rev_ready_i (link_rev_ready),
    .xcel_fwd_v_o     (xcel_fwd_v),
    .xcel_fwd_data_o  (xcel_fwd_data),
    .xcel_fwd_ready_i (xcel_fwd_ready),
    .xcel_rev_v_i     (xcel_rev_v),
    .xcel_rev_data_i  (xcel_rev_data),
    .xcel_rev_yumi_o  (xcel_rev_yumi),
    .outstanding_o    (outstanding),
    .error_o          (error)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nfail = 0;

  // Reference model state
  int        q[$];          // source link of each outstanding request, oldest first
  int        mp = 0;        // round-robin priority pointer
  bit        m_v = 0;       // output register occupied
  logic [FW-1:0] m_data = '0;
  bit        m_err = 0;
  int        last_grant = -1;
  int        gcount[NL];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NL-1:0] v, input int p);
    for (int k = 0; k < NL; k++) begin
      if (v[(p + k) % NL]) return (p + k) % NL;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    q.delete();
    mp = 0; m_v = 0; m_data = '0; m_err = 0;
  endfunction

  // One clock: check against the model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    logic [NL-1:0] e_yumi;
    logic [NL-1:0] e_rv;
    bit en, pop, spur;
    int g;
    @(negedge clk);
    en = (!m_v || xcel_fwd_ready) && (q.size() < DEPTH);
    g  = en ? pick(link_fwd_v, mp) : -1;
    e_yumi = '0;
    if (g >= 0) e_yumi[g] = 1'b1;
    e_rv = '0;
    pop  = 0;
    spur = xcel_rev_v && (q.size() == 0);
    if (xcel_rev_v && q.size() > 0) begin
      e_rv[q[0]] = 1'b1;
      pop = link_rev_ready[q[0]];
    end
    chk("fwd_yumi", link_fwd_yumi, e_yumi);
    chk("rev_v", link_rev_v, e_rv);
    chk("rev_yumi", xcel_rev_yumi, pop);
    chk("rev_data", link_rev_data, xcel_rev_data);
    chk("xcel_fwd_v", xcel_fwd_v, m_v);
    if (m_v) chk("xcel_fwd_data", xcel_fwd_data, m_data);
    chk("outstanding", outstanding, q.size());
    chk("error", error, m_err);
    last_grant = g;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (spur) m_err = 1;
    if (g >= 0) begin
      q.push_back(g);
      mp = (g + 1) % NL;
      m_v = 1;
      m_data = link_fwd_data[g*FW +: FW];
      gcount[g]++;
    end else if (xcel_fwd_ready) begin
      m_v = 0;
    end
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    link_fwd_v = '0;
    link_rev_ready = '1;
    xcel_fwd_ready = 1'b1;
    while ((q.size() > 0 || m_v) && n < 40) begin
      xcel_rev_v = (q.size() > 0);
      xcel_rev_data = RW'($urandom);
      cycle();
      n++;
    end
    xcel_rev_v = 1'b0;
    chk("drain_outstanding", outstanding, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    link_fwd_v = '0; link_fwd_data = '0; link_rev_ready = '0;
    xcel_fwd_ready = 1'b0; xcel_rev_v = 1'b0; xcel_rev_data = '0;
    for (int i = 0; i < NL; i++) gcount[i] = 0;
    #1;
    chk("rst_xcel_fwd_v", xcel_fwd_v, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_error", error, 0);
    chk("rst_fwd_yumi", link_fwd_yumi, 0);
    chk("rst_rev_v", link_rev_v, 0);
    chk("rst_rev_yumi", xcel_rev_yumi, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();

    // Single request from link 2, then its return.
    link_fwd_v = 4'b0100;
    link_fwd_data = {8'h11, 8'hA5, 8'h22, 8'h33};
    xcel_fwd_ready = 1'b1;
    link_rev_ready = '1;
    cycle();
    chk("single_grant", last_grant, 2);
    link_fwd_v = '0;
    #1;
    chk("single_fwd_v", xcel_fwd_v, 1);
    chk("single_fwd_data", xcel_fwd_data, 8'hA5);
    chk("single_outstanding", outstanding, 1);
    cycle();
    xcel_rev_v = 1'b1;
    xcel_rev_data = 8'h3C;
    #1;
    chk("single_rev_v", link_rev_v, 4'b0100);
    chk("single_rev_data", link_rev_data, 8'h3C);
    cycle();
    xcel_rev_v = 1'b0;
    #1;
    chk("single_outstanding_after", outstanding, 0);

    // Fairness: everyone requesting, returns flowing, 64 cycles.
    for (int i = 0; i < NL; i++) gcount[i] = 0;
    link_fwd_v = '1;
    for (int c = 0; c < 64; c++) begin
      link_fwd_data = $urandom;
      xcel_rev_v = (q.size() > 0);
      xcel_rev_data = RW'($urandom);
      cycle();
      chk("fair_grant_each_cycle", (last_grant >= 0), 1);
    end
    for (int i = 0; i < NL; i++) chk("fair_count", gcount[i], 16);
    drain();

    // Full tracking FIFO: returns withheld.
    link_fwd_v = '1;
    xcel_fwd_ready = 1'b1;
    xcel_rev_v = 1'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      link_fwd_data = $urandom;
      cycle();
      if (last_grant >= 0) n++;
    end
    chk("full_grants", n, DEPTH);
    chk("full_count", outstanding, DEPTH);
    chk("full_yumi_zero", link_fwd_yumi, 0);
    xcel_rev_v = 1'b1;
    cycle();
    chk("full_pop_no_grant", last_grant, -1);
    xcel_rev_v = 1'b0;
    cycle();
    chk("full_resume_grant", (last_grant >= 0), 1);
    cycle();
    chk("full_again_no_grant", last_grant, -1);
    drain();

    // Back-pressure: link 1's return blocks link 3's.
    link_fwd_v = 4'b0010; link_fwd_data = $urandom; cycle();
    link_fwd_v = 4'b1000; link_fwd_data = $urandom; cycle();
    link_fwd_v = '0;
    xcel_rev_v = 1'b1;
    link_rev_ready = 4'b1101;
    for (int c = 0; c < 3; c++) begin
      xcel_rev_data = RW'($urandom);
      #1;
      chk("bp_rev_v_blocked", link_rev_v, 4'b0010);
      chk("bp_yumi_blocked", xcel_rev_yumi, 0);
      cycle();
    end
    link_rev_ready = '1;
    cycle();
    #1;
    chk("bp_rev_v_link3", link_rev_v, 4'b1000);
    cycle();
    xcel_rev_v = 1'b0;
    drain();

    // Randomized traffic, returns only when something is outstanding.
    for (int c = 0; c < 400; c++) begin
      link_fwd_v = NL'($urandom);
      link_fwd_data = $urandom;
      xcel_fwd_ready = ($urandom_range(0, 3) != 0);
      link_rev_ready = NL'($urandom | $urandom);
      xcel_rev_v = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      xcel_rev_data = RW'($urandom);
      cycle();
    end
    drain();

    // Spurious return with nothing tracked.
    xcel_rev_v = 1'b1;
    xcel_rev_data = 8'h5A;
    #1;
    chk("spur_rev_v", link_rev_v, 0);
    chk("spur_yumi", xcel_rev_yumi, 0);
    cycle();
    chk("spur_error_set", error, 1);
    xcel_rev_v = 1'b0;
    cycle();
    cycle();
    chk("spur_error_sticky", error, 1);

    // Mid-operation reset with 5 requests outstanding.
    link_fwd_v = '1;
    xcel_fwd_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      link_fwd_data = $urandom;
      cycle();
    end
    link_fwd_v = '0;
    chk("mid_outstanding_before", outstanding, 5);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_fwd_v", xcel_fwd_v, 0);
    chk("mid_rst_outstanding", outstanding, 0);
    chk("mid_rst_error", error, 0);
    chk("mid_rst_fwd_yumi", link_fwd_yumi, 0);
    chk("mid_rst_rev_v", link_rev_v, 0);
    chk("mid_rst_rev_yumi", xcel_rev_yumi, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    link_fwd_v = '1;
    link_fwd_data = $urandom;
    cycle();
    chk("mid_first_grant", last_grant, 0);
    link_fwd_v = '0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
